mem_access_controller: RTL

MEM_ACCESS_CONTROLLER -- requirements
Module: mem_access_controller

---
 rtl/mem_access_controller.sv | 106 ++++++++++
 1 files changed

// File: rtl/mem_access_controller.sv
// Single-request memory access sequencer with an ack timeout.
// Accepts one read or write from IDLE, waits for i_mem_ack, and reports done or error.
module mem_access_controller #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_rd_req,
  input  logic                  i_wr_req,
  input  logic [DATA_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_err,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [DATA_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_ack,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE,
    ERR
  } state_t;

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  state_t                r_state;
  state_t                w_next;
  logic [7:0]            r_cnt;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_we;
  logic                  r_err;
  logic                  w_accept;
  logic                  w_ack;
  logic                  w_tout;

  assign w_accept = (r_state == IDLE) &&
                    (i_rd_req || i_wr_req);
  assign w_ack    = (r_state == ACCESS) && i_mem_ack;
  assign w_tout   = (r_state == ACCESS) && !i_mem_ack &&
                    (r_cnt == LP_LAST);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = ACCESS;
      ACCESS: begin
        // Ack beats a coincident timeout.
        if (w_ack)       w_next = DONE;
        else if (w_tout) w_next = ERR;
      end
      DONE:    w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rd_data <= '0;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr  <= i_addr;
        r_wdata <= i_wr_data;
        r_we    <= i_wr_req && !i_rd_req;
        r_cnt   <= '0;
        r_err   <= 1'b0;
      end
      if (r_state == ACCESS) begin
        if (w_ack) begin
          if (!r_we) r_rd_data <= i_mem_rdata;
        end else begin
          r_cnt <= r_cnt + 8'd1;
          if (w_tout) r_err <= 1'b1;
        end
      end
    end
  end

  assign o_busy      = (r_state != IDLE);
  assign o_done      = (r_state == DONE) ||
                       (r_state == ERR);
  assign o_mem_req   = (r_state == ACCESS);
  assign o_mem_we    = r_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_rd_data   = r_rd_data;
  assign o_err       = r_err;

endmodule
